// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int calc_tick_div(input int clock_freq, input int baud_rate,
                                       input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clock tick every TICK_DIV clocks.
module uart_baud_tick #(
  parameter int TICK_DIV = 325
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // With TICK_DIV=1 the counter sits at 0 and tick stays high.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_8n1_os.sv
// 8N1 UART receiver, oversampled with mid-bit sampling, glitch rejection,
// framing-error and overrun reporting; bytes delivered on valid/ready.
module uart_rx_8n1_os
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  logic        tick;
  logic [1:0]  sync;
  logic        rx_s;
  uart_state_e state, state_n;
  logic [SW-1:0] s, s_n;
  logic [2:0]  b, b_n;
  logic [7:0]  sh, sh_n;
  logic        deliver, ferr;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  // State register (with the sample/bit counters and shift register).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      b     <= b_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    sh_n    = sh;
    if (tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
        START: if (s == S_HALF) begin
          state_n = rx_s ? IDLE : DATA;
          s_n     = '0;
          b_n     = '0;
        end else s_n = s + 1'b1;
        DATA: if (s == S_LAST) begin
          sh_n[b] = rx_s;
          s_n     = '0;
          if (b == 3'd7) state_n = STOP;
          else           b_n     = b + 1'b1;
        end else s_n = s + 1'b1;
        STOP: if (s == S_LAST) begin
          state_n = rx_s ? IDLE : WAIT_HI;
          s_n     = '0;
        end else s_n = s + 1'b1;
        WAIT_HI: if (rx_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (state != IDLE);
    deliver = tick && (state == STOP) && (s == S_LAST) && rx_s;
    ferr    = tick && (state == STOP) && (s == S_LAST) && !rx_s;
  end

  // A transfer in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= sh;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
